// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state type and ALU opcode constants
// for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters
// plus a response consumer (master) and the arbiter (slave).
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);

    logic [1:0]                          req_valid;
    logic [1:0]                          req_ready;
    logic [1:0][DATA_WIDTH-1:0]          req_src_a;
    logic [1:0][DATA_WIDTH-1:0]          req_src_b;
    logic [1:0][OPCODE_LENGTH-1:0]       req_op;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic                                rsp_id;
    logic [DATA_WIDTH-1:0]               rsp_result;

    modport master (
        output req_valid,
        output req_src_a,
        output req_src_b,
        output req_op,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_result
    );

    modport slave (
        input  req_valid,
        input  req_src_a,
        input  req_src_b,
        input  req_op,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_result
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational ALU (AND/OR/ADD/SUB/EQ/XOR); unknown
// opcodes yield zero, ADD/SUB wrap at DATA_WIDTH bits.
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    a,
    input  logic [DATA_WIDTH-1:0]    b,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result
);

    // Decode the opcode and compute the selected operation
    always_comb begin
        result = '0;
        case (op)
            OPCODE_LENGTH'(OP_AND): result = a & b;
            OPCODE_LENGTH'(OP_OR):  result = a | b;
            OPCODE_LENGTH'(OP_ADD): result = a + b;
            OPCODE_LENGTH'(OP_SUB): result = a - b;
            OPCODE_LENGTH'(OP_EQ):  result = DATA_WIDTH'(a == b);
            OPCODE_LENGTH'(OP_XOR): result = a ^ b;
            default:                result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; default is port 0 priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_t                   state;
    state_t                   state_nxt;
    logic                     gnt;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    a_q;
    logic [DATA_WIDTH-1:0]    b_q;
    logic [OPCODE_LENGTH-1:0] op_q;
    logic                     id_q;
    logic [DATA_WIDTH-1:0]    alu_out;
    logic [DATA_WIDTH-1:0]    result_q;
    logic                     rsp_id_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Remember the most recently accepted port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt;
        end
    end

    assign gnt = (&bus.req_valid) ? ~last_q : ~bus.req_valid[0];
`else
    assign gnt = ~bus.req_valid[0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-cycle accept strobe
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = 2'b00;
        unique case (state)
            IDLE: begin
                if ((|bus.req_valid) && rst_n) begin
                    accept        = 1'b1;
                    bus.req_ready = gnt ? 2'b10 : 2'b01;
                    state_nxt     = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture operands on accept, register the result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= bus.req_src_a[gnt];
                b_q  <= bus.req_src_b[gnt];
                op_q <= bus.req_op[gnt];
                id_q <= gnt;
            end
            if (state == EXEC) begin
                result_q <= alu_out;
                rsp_id_q <= id_q;
            end
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_out)
    );

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = result_q;

endmodule
